// File: rtl/l1_pkg.sv
// Shared types and field widths for the L1 read cache.
// Address layout: {tag[10:8], index[7:4], offset[3:0]}.
package l1_pkg;
  localparam int OFFSET_W = 4;
  localparam int INDEX_W  = 4;
  localparam int TAG_W    = 3;
  localparam int ADDR_W   = OFFSET_W + INDEX_W + TAG_W;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    L2_REQ,
    L2_WAIT,
    MEM_WAIT
  } state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/l1_tag_array.sv
// Direct-mapped valid/tag/data storage: combinational read, synchronous fill.
// Valid bits clear asynchronously on reset; tag and data contents are left as-is.
module l1_tag_array
  import l1_pkg::*;
#(
  parameter int NUM_BLOCKS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [INDEX_W-1:0] index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              fill_en,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [DATA_W-1:0] fill_data
);
  logic [NUM_BLOCKS-1:0] valid;
  logic [TAG_W-1:0]      tags  [NUM_BLOCKS];
  logic [DATA_W-1:0]     words [NUM_BLOCKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= '0;
    end else if (fill_en) begin
      valid[index] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tags[index]  <= fill_tag;
      words[index] <= fill_data;
    end
  end

  assign rd_valid = valid[index];
  assign rd_tag   = tags[index];
  assign rd_data  = words[index];
endmodule

// File: rtl/l1_cache.sv
// Read-only direct-mapped L1: hit done 2 edges after accept, misses go to L2 then memory.
// One request at a time; cpu_busy is high outside IDLE and new requests are ignored then.
module l1_cache
  import l1_pkg::*;
#(
  parameter int CACHE_SIZE = 256,
  parameter int BLOCK_SIZE = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_busy,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_data,
  output logic              l1_miss,
  output logic [ADDR_W-1:0] l2_addr,
  input  logic              l2_hit,
  input  logic              l2_miss,
  input  logic [DATA_W-1:0] l2_data,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [CNT_W-1:0]  l1_hits,
  output logic [CNT_W-1:0]  l2_hits,
  output logic [CNT_W-1:0]  mem_fills
);
  localparam int NUM_BLOCKS = CACHE_SIZE / BLOCK_SIZE;

  state_t              state, state_nxt;
  logic                done_nxt, miss_nxt, mem_req_nxt;
  logic [DATA_W-1:0]   data_nxt;
  logic [ADDR_W-1:0]   addr_nxt;
  logic                fill_en;
  logic [DATA_W-1:0]   fill_data;
  logic                inc_l1, inc_l2, inc_mem;
  logic                rd_valid;
  logic [TAG_W-1:0]    rd_tag;
  logic [DATA_W-1:0]   rd_data;
  logic [INDEX_W-1:0]  blk_index;
  logic [TAG_W-1:0]    blk_tag;

  assign blk_index = l2_addr[OFFSET_W +: INDEX_W];
  assign blk_tag   = l2_addr[OFFSET_W + INDEX_W +: TAG_W];

  l1_tag_array #(.NUM_BLOCKS(NUM_BLOCKS)) u_tag_array (
    .clk      (clk),
    .rst_n    (rst_n),
    .index    (blk_index),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .fill_en  (fill_en),
    .fill_tag (blk_tag),
    .fill_data(fill_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    miss_nxt    = 1'b0;
    mem_req_nxt = mem_req;
    data_nxt    = cpu_data;
    addr_nxt    = l2_addr;
    fill_en     = 1'b0;
    fill_data   = l2_data;
    inc_l1      = 1'b0;
    inc_l2      = 1'b0;
    inc_mem     = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) begin
          addr_nxt  = cpu_addr;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (rd_valid && (rd_tag == blk_tag)) begin
          data_nxt  = rd_data;
          done_nxt  = 1'b1;
          inc_l1    = 1'b1;
          state_nxt = IDLE;
        end else begin
          miss_nxt  = 1'b1;
          state_nxt = L2_REQ;
        end
      end
      L2_REQ: state_nxt = L2_WAIT;
      L2_WAIT: begin
        // A simultaneous hit and miss from L2 is resolved as a miss.
        if (l2_miss) begin
          mem_req_nxt = 1'b1;
          state_nxt   = MEM_WAIT;
        end else if (l2_hit) begin
          fill_en   = 1'b1;
          fill_data = l2_data;
          data_nxt  = l2_data;
          done_nxt  = 1'b1;
          inc_l2    = 1'b1;
          state_nxt = IDLE;
        end
      end
      MEM_WAIT: begin
        if (mem_ack) begin
          mem_req_nxt = 1'b0;
          fill_en     = 1'b1;
          fill_data   = mem_data;
          data_nxt    = mem_data;
          done_nxt    = 1'b1;
          inc_mem     = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_busy  <= 1'b0;
      cpu_done  <= 1'b0;
      cpu_data  <= '0;
      l1_miss   <= 1'b0;
      l2_addr   <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
      l1_hits   <= '0;
      l2_hits   <= '0;
      mem_fills <= '0;
    end else begin
      cpu_busy <= (state_nxt != IDLE);
      cpu_done <= done_nxt;
      cpu_data <= data_nxt;
      l1_miss  <= miss_nxt;
      l2_addr  <= addr_nxt;
      mem_req  <= mem_req_nxt;
      mem_addr <= mem_req_nxt ? addr_nxt : '0;
      if (inc_l1)  l1_hits   <= sat_inc(l1_hits);
      if (inc_l2)  l2_hits   <= sat_inc(l2_hits);
      if (inc_mem) mem_fills <= sat_inc(mem_fills);
    end
  end
endmodule

// File: tb/tb_l1_cache.sv
// Directed bench for l1_cache: a transaction-level cache model predicts every read,
// a per-cycle compare process checks the DUT against it, L2/memory are behavioural responders.
module tb_l1_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cpu_req = 1'b0;
  logic [10:0] cpu_addr = '0;
  logic        cpu_busy, cpu_done, l1_miss, mem_req;
  logic [31:0] cpu_data;
  logic [10:0] l2_addr, mem_addr;
  logic        l2_hit = 1'b0, l2_miss = 1'b0, mem_ack = 1'b0;
  logic [31:0] l2_data = '0, mem_data = '0;
  logic [15:0] l1_hits, l2_hits, mem_fills;

  always #5 clk = ~clk;

  l1_cache #(.CACHE_SIZE(256), .BLOCK_SIZE(16)) dut (
    .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
    .cpu_busy(cpu_busy), .cpu_done(cpu_done), .cpu_data(cpu_data),
    .l1_miss(l1_miss), .l2_addr(l2_addr), .l2_hit(l2_hit), .l2_miss(l2_miss),
    .l2_data(l2_data), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_data(mem_data), .l1_hits(l1_hits), .l2_hits(l2_hits), .mem_fills(mem_fills)
  );

  int nchk = 0, nerr = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Responder configuration: l2_mode 0 = hit, 1 = miss, 2 = hit and miss together.
  int          l2_mode = 0;
  logic [31:0] l2_val = '0;
  int          mem_lat = 1;
  logic [31:0] mem_val = '0;

  // Transaction published by the driver; outcome kind 0 = L1 hit, 1 = L2 fill, 2 = memory fill.
  int          issued = 0;
  logic [10:0] t_addr = '0;
  int          t_kind = 0;
  logic [31:0] t_val = '0;
  int          t_acc = 0;
  int          pre_gen = 0;

  // Cache model, owned by the compare process.
  bit          m_valid [16];
  logic [2:0]  m_tag   [16];
  logic [31:0] m_data  [16];
  logic [15:0] m_l1 = '0, m_l2 = '0, m_mem = '0;
  logic [31:0] m_last = '0;
  int          completed = 0, t_misses = 0, t_memcyc = 0, last_lat = 0, pre_seen = 0;

  always @(negedge clk) begin : compare
    int idx, lat;
    bit pend, busy_exp;
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_l1 = '0; m_l2 = '0; m_mem = '0; m_last = '0;
      completed = issued; t_misses = 0; t_memcyc = 0; pre_seen = pre_gen;
    end else begin
      if (pre_seen != pre_gen) begin
        m_l1 = 16'hFFFE;
        pre_seen = pre_gen;
      end
      pend = (issued != completed);
      busy_exp = pend && !cpu_done;
      chk("cpu_busy", 32'(cpu_busy), 32'(busy_exp));
      if (!pend) begin
        chk("stray_cpu_done", 32'(cpu_done), 32'd0);
        chk("stray_l1_miss", 32'(l1_miss), 32'd0);
        chk("stray_mem_req", 32'(mem_req), 32'd0);
      end else begin
        if (l1_miss) begin
          t_misses++;
          chk("l2_addr", 32'(l2_addr), 32'(t_addr));
        end
        if (mem_req) begin
          t_memcyc++;
          chk("mem_addr", 32'(mem_addr), 32'(t_addr));
          chk("l2_addr_hold", 32'(l2_addr), 32'(t_addr));
        end
        if (cpu_done) begin
          idx = int'(t_addr[7:4]);
          lat = cyc - t_acc + 1;
          if (t_kind == 0) begin
            m_l1 = sat16(m_l1);
            m_last = m_data[idx];
            chk("hit_latency", 32'(lat), 32'd2);
          end else begin
            m_valid[idx] = 1'b1;
            m_tag[idx] = t_addr[10:8];
            m_data[idx] = t_val;
            m_last = t_val;
            if (t_kind == 1) begin
              m_l2 = sat16(m_l2);
              chk("l2_latency", 32'(lat), 32'd4);
            end else begin
              m_mem = sat16(m_mem);
            end
          end
          chk("l1_miss_pulses", 32'(t_misses), (t_kind != 0) ? 32'd1 : 32'd0);
          chk("mem_req_seen", 32'(t_memcyc > 0), (t_kind == 2) ? 32'd1 : 32'd0);
          last_lat = lat;
          t_misses = 0;
          t_memcyc = 0;
          completed = issued;
        end
      end
      chk("cpu_data", cpu_data, m_last);
      chk("l1_hits", 32'(l1_hits), 32'(m_l1));
      chk("l2_hits", 32'(l2_hits), 32'(m_l2));
      chk("mem_fills", 32'(mem_fills), 32'(m_mem));
    end
  end

  // L2: registered response on the cycle after the l1_miss pulse.
  initial begin : l2_model
    forever begin
      @(negedge clk);
      if (rst_n && l1_miss) begin
        @(posedge clk); #1;
        l2_hit = (l2_mode != 1);
        l2_miss = (l2_mode != 0);
        l2_data = l2_val;
        @(posedge clk); #1;
        l2_hit = 1'b0;
        l2_miss = 1'b0;
        l2_data = 32'h0BAD0BAD;
      end
    end
  end

  // Memory: acks mem_lat cycles after seeing mem_req; a reset abandons the request.
  initial begin : mem_model
    forever begin
      @(negedge clk);
      if (rst_n && mem_req) begin
        bit aborted;
        aborted = 1'b0;
        for (int i = 0; i < mem_lat; i++) begin
          @(posedge clk);
          if (!rst_n) aborted = 1'b1;
        end
        if (!aborted && rst_n) begin
          #1;
          mem_ack = 1'b1;
          mem_data = mem_val;
          @(posedge clk); #1;
          mem_ack = 1'b0;
          mem_data = 32'h0BADF00D;
        end
      end
    end
  end

  task automatic issue(input logic [10:0] a, input int mode, input logic [31:0] lv,
                       input int ml, input logic [31:0] mv);
    int idx;
    l2_mode = mode; l2_val = lv; mem_lat = ml; mem_val = mv;
    idx = int'(a[7:4]);
    t_addr = a;
    if (m_valid[idx] && m_tag[idx] == a[10:8]) begin
      t_kind = 0;
    end else if (mode == 0) begin
      t_kind = 1; t_val = lv;
    end else begin
      t_kind = 2; t_val = mv;
    end
    @(posedge clk); #1;
    cpu_req = 1'b1;
    cpu_addr = a;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    t_acc = cyc;
    issued++;
  endtask

  task automatic do_read(input logic [10:0] a, input int mode, input logic [31:0] lv,
                         input int ml, input logic [31:0] mv, input bit poke);
    bit poked;
    int n;
    issue(a, mode, lv, ml, mv);
    poked = 1'b0;
    n = 0;
    while (issued != completed && n < 300) begin
      @(negedge clk); #1;
      n++;
      if (poke && !poked && mem_req) begin
        cpu_req = 1'b1;
        cpu_addr = 11'h7FF;
        chk("busy_during_poke", 32'(cpu_busy), 32'd1);
        @(negedge clk); #1;
        cpu_req = 1'b0;
        poked = 1'b1;
      end
    end
    if (issued != completed) begin
      chk("read_timeout", 32'd1, 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : main
    #2 rst_n = 1'b0;
    #10;
    chk("rst_cpu_busy", 32'(cpu_busy), 32'd0);
    chk("rst_cpu_done", 32'(cpu_done), 32'd0);
    chk("rst_cpu_data", cpu_data, 32'd0);
    chk("rst_l1_miss", 32'(l1_miss), 32'd0);
    chk("rst_l2_addr", 32'(l2_addr), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_counters", 32'({l1_hits, l2_hits} | {16'd0, mem_fills}), 32'd0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Cold miss all the way to memory.
    do_read(11'h123, 1, 32'h0, 4, 32'hDEADBEEF, 1'b0);
    chk("fill_data_deadbeef", cpu_data, 32'hDEADBEEF);
    chk("mem_fills_one", 32'(mem_fills), 32'd1);

    // Same block, different offset: L1 hit.
    do_read(11'h12C, 0, 32'h0, 4, 32'h0, 1'b0);
    chk("hit_data", cpu_data, 32'hDEADBEEF);
    chk("l1_hits_one", 32'(l1_hits), 32'd1);
    chk("hit_lat_literal", 32'(last_lat), 32'd2);

    // Same index, new tag: L2 hit evicts, re-read of 0x123 misses L1.
    do_read(11'h223, 0, 32'hFEEDFACE, 4, 32'h0, 1'b0);
    chk("l2_fill_data", cpu_data, 32'hFEEDFACE);
    chk("l2_hits_one", 32'(l2_hits), 32'd1);
    chk("l2_lat_literal", 32'(last_lat), 32'd4);
    do_read(11'h123, 0, 32'h11112222, 4, 32'h0, 1'b0);
    chk("evicted_refill", cpu_data, 32'h11112222);
    chk("l1_hits_unchanged", 32'(l1_hits), 32'd1);

    // Both L2 responses high counts as miss; minimum memory latency.
    do_read(11'h5A0, 2, 32'h33333333, 1, 32'hA5A5A5A5, 1'b0);
    chk("both_is_miss", cpu_data, 32'hA5A5A5A5);
    chk("l2_hits_still_two", 32'(l2_hits), 32'd2);

    // cpu_req during MEM_WAIT is ignored.
    do_read(11'h345, 1, 32'h0, 6, 32'hCAFEF00D, 1'b1);
    chk("poke_data", cpu_data, 32'hCAFEF00D);
    chk("poke_one_fill", 32'(mem_fills), 32'd3);

    // Reset while waiting on memory.
    begin : reset_mid_miss
      int n;
      issue(11'h456, 1, 32'h0, 40, 32'h99999999);
      n = 0;
      while (!mem_req && n < 20) begin
        @(negedge clk); #1;
        n++;
      end
      chk("reached_mem_wait", 32'(mem_req), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_req", 32'(mem_req), 32'd0);
      chk("abort_busy", 32'(cpu_busy), 32'd0);
      chk("abort_data", cpu_data, 32'd0);
      chk("abort_mem_fills", 32'(mem_fills), 32'd0);
      chk("abort_l1_hits", 32'(l1_hits), 32'd0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (45) @(negedge clk);
    end
    do_read(11'h123, 0, 32'h600D600D, 4, 32'h0, 1'b0);
    chk("post_reset_miss", 32'(l2_hits), 32'd1);
    chk("post_reset_l1", 32'(l1_hits), 32'd0);

    // Counter saturation.
    @(posedge clk); #2;
    force dut.l1_hits = 16'hFFFE;
    pre_gen++;
    @(negedge clk); #1;
    release dut.l1_hits;
    chk("preload", 32'(l1_hits), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) do_read(11'h123, 0, 32'h0, 4, 32'h0, 1'b0);
    chk("saturated", 32'(l1_hits), 32'h0000FFFF);
    chk("sat_data", cpu_data, 32'h600D600D);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/l1_cache.md
L1_CACHE -- requirements
Module: l1_cache

Interface
REQ-001 Parameter CACHE_SIZE, default 256, bytes of L1 data capacity.
REQ-002 Parameter BLOCK_SIZE, default 16, bytes per block; NUM_BLOCKS = CACHE_SIZE/BLOCK_SIZE (16).
REQ-003 clk  in  1  single clock; all state updates on posedge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 cpu_req  in  1  read request; sampled only in IDLE.
REQ-006 cpu_addr  in  11  byte address; offset [3:0], index [7:4], tag [10:8].
REQ-007 cpu_busy  out  1  high whenever state != IDLE.
REQ-008 cpu_done  out  1  one-cycle pulse; cpu_data valid on the same cycle.
REQ-009 cpu_data  out  32  read data; holds last value until the next cpu_done.
REQ-010 l1_miss  out  1  request to L2; one-cycle pulse per L1 miss.
REQ-011 l2_addr  out  11  latched request address; stable from the l1_miss pulse until IDLE.
REQ-012 l2_hit, l2_miss  in  1 each  L2 registered response; arrives on the cycle after l1_miss.
REQ-013 l2_data  in  32  L2 data; valid when l2_hit=1.
REQ-014 mem_req  out  1  memory read request; level, held until mem_ack.
REQ-015 mem_addr  out  11  equals l2_addr while mem_req=1.
REQ-016 mem_ack, mem_data  in  1, 32  memory completion and data; any latency >= 1 cycle.
REQ-017 l1_hits, l2_hits, mem_fills  out  16 each  saturating event counters.

Function
REQ-018 Direct-mapped; per block: valid bit, 3-bit tag, 32-bit data word.
REQ-019 States: IDLE, LOOKUP, L2_REQ, L2_WAIT, MEM_WAIT; all outputs registered.
REQ-020 IDLE: cpu_req=1 latches cpu_addr -> LOOKUP; otherwise stay in IDLE.
REQ-021 LOOKUP: valid and tag match -> cpu_data=block data, cpu_done=1, l1_hits+1, -> IDLE (done 2 cycles after accept edge).
REQ-022 LOOKUP miss -> l1_miss=1 for one cycle, -> L2_REQ; next edge l1_miss=0, -> L2_WAIT.
REQ-023 L2_WAIT: l2_hit=1 -> fill block (valid=1, tag, l2_data), cpu_data=l2_data, cpu_done=1, l2_hits+1, -> IDLE.
REQ-024 L2_WAIT: l2_miss=1 -> mem_req=1, -> MEM_WAIT; l2_hit and l2_miss both high is treated as miss.
REQ-025 L2_WAIT with neither response: remain in L2_WAIT, no timeout.
REQ-026 MEM_WAIT: mem_ack=1 -> mem_req=0, fill block with mem_data, cpu_data=mem_data, cpu_done=1, mem_fills+1, -> IDLE.
REQ-027 A fill overwrites the indexed block unconditionally (no write-back; read-only cache).
REQ-028 cpu_req outside IDLE is ignored; no request queue.
REQ-029 mem_ack outside MEM_WAIT and l2_hit/l2_miss outside L2_WAIT are ignored.
REQ-030 Counters saturate at 16'hFFFF; no wrap.

Reset
REQ-031 rst_n=0 asynchronously forces IDLE, clears all valid bits and counters, and drives all outputs to 0, including cpu_data.
REQ-032 Reset mid-miss aborts the transaction; no cpu_done is issued and no fill occurs.
REQ-033 Tag and data arrays need no reset.

Structure
REQ-034 Shared package l1_pkg holds the state enum, address field widths (OFFSET_W=4, INDEX_W=4, TAG_W=3), and the counter width.
REQ-035 One sub-module, l1_tag_array (valid/tag/data storage, combinational read, synchronous fill write, asynchronous valid clear).

Verification
REQ-036 Reset, read 0x123; L2 model misses; memory acks after 4 cycles with 0xDEADBEEF -> cpu_done, cpu_data=0xDEADBEEF, mem_fills=1.
REQ-037 Then read 0x12C (same block) -> cpu_done 2 cycles after accept, data 0xDEADBEEF, l1_hits=1, no l1_miss.
REQ-038 Read 0x223 (index 2, tag 2) with L2 hit returning 0xFEEDFACE -> done 4 cycles after accept, l2_hits=1; re-read 0x123 -> L1 miss (evicted).
REQ-039 cpu_req pulses during MEM_WAIT -> ignored, cpu_busy=1, exactly one cpu_done.
REQ-040 rst_n low during MEM_WAIT -> mem_req=0 immediately, counters 0, next read of 0x123 misses L1.
REQ-041 Preload l1_hits=16'hFFFE, then 3 hits -> l1_hits=16'hFFFF.
